commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
//  Downstream observer of the riscv core: captures register writebacks (reg_write_sig/reg_num/reg_data)
//  and data-memory accesses (wr/rd/addr/wr_data/rd_data) as trace records, queues them in a FIFO,
//  and drains them over a valid/ready port to a trace sink (testbench monitor or debug UART).
//  Non-intrusive: never stalls the core; drops and counts events when the FIFO cannot absorb them.
// PARAMETERS
//  DATA_W  32  data width of reg_data / wr_data / rd_data
//  ADDR_W  9   data-memory address width (matches core addr port)
//  DEPTH   8   FIFO entries; power of two, >= 2
//  TS_W    16  timestamp field width
//  OVF_W   8   dropped-event counter width (saturating)
// PORTS
//  clk            in   1                  core clock
//  reset          in   1                  synchronous, active-high
//  reg_write_sig  in   1                  core register-file write strobe
//  reg_num        in   5                  destination register
//  reg_data       in   DATA_W             writeback data
//  wr             in   1                  data-memory store strobe
//  rd             in   1                  data-memory load strobe
//  addr           in   ADDR_W             data-memory address
//  wr_data        in   DATA_W             store data
//  rd_data        in   DATA_W             load data
//  out_valid      out  1                  head record available
//  out_ready      in   1                  sink accepts head record
//  out_record     out  REC_W              {kind[1:0], tag[ADDR_W-1:0], data[DATA_W-1:0], stamp[TS_W-1:0]}
//  level          out  $clog2(DEPTH)+1    occupied entries
//  overflow_cnt   out  OVF_W              dropped events, saturates at all-ones
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. On reset: out_valid=0, level=0,
//    overflow_cnt=0, pointers=0, stamp counter=0, out_record=0; queued contents discarded,
//    including reset asserted mid-drain. Inputs sampled during the reset cycle are ignored.
//  - Event capture (same cycle as strobes, combinational qualify, registered push):
//    REG  kind=2'b00: reg_write_sig && reg_num!=0; tag={zero-extend reg_num}, data=reg_data.
//    STORE kind=2'b01: wr; tag=addr, data=wr_data.  LOAD kind=2'b10: rd && !wr; tag=addr, data=rd_data.
//    wr&&rd together -> single STORE. Writes to x0 never recorded.
//  - Up to 2 pushes/cycle (REG + one memory event); order in FIFO: REG first, then memory event.
//  - Pop: when out_valid && out_ready, head retires that cycle; out_record/out_valid update next edge.
//    out_record is show-ahead (head visible while out_valid=1), stable while out_valid && !out_ready.
//  - Space rule: avail = DEPTH - level + pop_this_cycle (pop frees slot for same-cycle push).
//    If needed pushes > avail: keep earliest-ordered events that fit, drop rest; overflow_cnt += dropped
//    (0..2), saturating at 2^OVF_W-1, never wraps.
//  - Pointers wrap modulo DEPTH; level = pushes - pops accumulated, 0..DEPTH; out_valid = (level!=0).
//  - Full with pop and 2 events: 1 pushed, 1 dropped. Empty with push: out_valid rises 1 cycle later.
//  - Latency strobe->out_valid on empty FIFO: 1 cycle.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter (from 0 at reset, wraps) stamps
//   each record with the capture cycle. Undefined: counter not built, stamp field constant 0;
//   REC_W unchanged so sink format is identical.
// STRUCTURE
//  Package trace_pkg: trace_kind_e enum {TK_REG, TK_STORE, TK_LOAD}, trace_rec_t packed struct,
//   REC_W localparam derivation function.
//  Sub-module trace_fifo_2w1r: DEPTH-entry dual-push/single-pop FIFO with avail output;
//   commit_trace_buffer holds qualify logic, drop/saturation counter, timestamp.
// TESTING
//  1 reset: drive strobes during reset -> after release out_valid=0, level=0, overflow_cnt=0.
//  2 reg_write_sig=1, reg_num=5, reg_data=32'hDEAD_BEEF, out_ready=0 -> next cycle out_valid=1,
//    kind=00, tag=5, data=DEADBEEF; record held stable for 3 stalled cycles; x0 write produces nothing.
//  3 same cycle reg x7=1 and wr addr=9'h010 wr_data=32'h55 -> two records, REG then STORE, level=2.
//  4 out_ready=0, fill 8 entries, then 3 more dual events -> level=8, overflow_cnt=6; with
//    OVF_W=2 repeated overflow saturates at 3.
//  5 full FIFO, out_ready=1, one rd addr=9'h1FF rd_data=32'h1 -> pop+push same cycle, level stays 8,
//    no drop; wr&&rd together -> single STORE record.
//  6 TRACE_TIMESTAMP_EN on: events at cycles 3 and 10 after reset -> stamps 3 and 10;
//    macro off -> stamp=0 in every record.

Source files
------------

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types and helpers for the commit trace buffer.
//               Record kinds, the default-width record layout, and a
//               constant function deriving the record width from the
//               data, address and timestamp field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Record kind field (record MSBs). 2'b11 is never produced.
    typedef enum logic [1:0] {
        TK_REG   = 2'b00,
        TK_STORE = 2'b01,
        TK_LOAD  = 2'b10
    } trace_kind_e;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 9;
    localparam int c_DEF_TS_W   = 16;

    // Record layout for the default configuration. Field order matches the
    // flat out_record vector: {kind, tag, data, stamp}, kind in the MSBs.
    typedef struct packed {
        trace_kind_e               kind;
        logic [c_DEF_ADDR_W-1:0]   tag;
        logic [c_DEF_DATA_W-1:0]   data;
        logic [c_DEF_TS_W-1:0]     stamp;
    } trace_rec_t;

    // Width of one flat trace record for arbitrary field widths.
    function automatic int rec_width(input int addr_w, input int data_w, input int ts_w);
        return 2 + addr_w + data_w + ts_w;
    endfunction

    localparam int c_DEF_REC_W = rec_width(c_DEF_ADDR_W, c_DEF_DATA_W, c_DEF_TS_W);

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo_2w1r.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo_2w1r
// Description : DEPTH-entry FIFO accepting up to two pushes and one pop per
//               cycle. Show-ahead head output (zero when empty). Reports the
//               slots available to pushes this cycle, counting a slot freed
//               by a same-cycle pop.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_push_cnt        - number of pushes this cycle (0..2); the
//                                   caller guarantees i_push_cnt <= o_avail
//               i_push_data0/1    - push payloads, data0 is written first
//               i_pop             - retire head (ignored when empty)
//               o_head_data       - head entry, zero while empty
//               o_head_valid      - FIFO not empty
//               o_level           - occupied entries, 0..DEPTH
//               o_avail           - DEPTH - level + effective pop
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo_2w1r #(
    parameter int WIDTH = 59,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 i_push_cnt,
    input  logic [WIDTH-1:0]           i_push_data0,
    input  logic [WIDTH-1:0]           i_push_data1,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic                       o_head_valid,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [$clog2(DEPTH):0]     o_avail
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_LVL_W-1:0] r_level;

    logic               w_not_empty;
    logic               w_pop_ok;
    logic [c_PTR_W-1:0] w_wptr_next_slot;

    assign w_not_empty      = (r_level != '0);
    assign w_pop_ok         = i_pop && w_not_empty;
    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign w_wptr_next_slot = r_wptr + (c_PTR_W)'(1);

    // Storage carries no reset: an entry is only observable once the level
    // covers it, and the head output is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (i_push_cnt != 2'd0) begin
            r_mem[r_wptr] <= i_push_data0;
        end
        if (i_push_cnt == 2'd2) begin
            r_mem[w_wptr_next_slot] <= i_push_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= r_wptr + (c_PTR_W)'(i_push_cnt);
            if (w_pop_ok) begin
                r_rptr <= r_rptr + (c_PTR_W)'(1);
            end
            r_level <= r_level + (c_LVL_W)'(i_push_cnt) - (c_LVL_W)'(w_pop_ok);
        end
    end

    assign o_head_valid = w_not_empty;
    assign o_head_data  = w_not_empty ? r_mem[r_rptr] : '0;
    assign o_level      = r_level;
    // A pop in this cycle frees its slot for a push in the same cycle.
    assign o_avail      = (c_LVL_W)'(DEPTH) - r_level + (c_LVL_W)'(w_pop_ok);

endmodule : trace_fifo_2w1r
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Non-intrusive trace observer for the riscv core. Captures
//               register writebacks and data-memory accesses as trace
//               records, queues them, and drains them over a valid/ready
//               port. Never back-pressures the core: events that do not fit
//               are dropped and counted in a saturating counter.
// Config      : TRACE_TIMESTAMP_EN - when defined, a free-running TS_W-bit
//               cycle counter stamps each record with its capture cycle.
//               When undefined the stamp field is constant zero; the record
//               width is the same either way.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               reg_write_sig     - register-file write strobe
//               reg_num, reg_data - destination register and writeback data
//               wr, rd            - data-memory store / load strobes
//               addr              - data-memory address
//               wr_data, rd_data  - store / load data
//               out_valid         - head record available
//               out_ready         - sink accepts head record
//               out_record        - {kind[1:0], tag, data, stamp}
//               level             - occupied FIFO entries
//               overflow_cnt      - dropped events, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16,
    parameter int OVF_W  = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          reg_write_sig,
    input  logic [4:0]                                    reg_num,
    input  logic [DATA_W-1:0]                             reg_data,
    input  logic                                          wr,
    input  logic                                          rd,
    input  logic [ADDR_W-1:0]                             addr,
    input  logic [DATA_W-1:0]                             wr_data,
    input  logic [DATA_W-1:0]                             rd_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [rec_width(ADDR_W, DATA_W, TS_W)-1:0]    out_record,
    output logic [$clog2(DEPTH):0]                        level,
    output logic [OVF_W-1:0]                              overflow_cnt
);

    localparam int c_REC_W = rec_width(ADDR_W, DATA_W, TS_W);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
    logic [TS_W-1:0] w_stamp;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_stamp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + (TS_W)'(1);
        end
    end

    assign w_stamp = r_stamp;
`else
    assign w_stamp = '0;
`endif

    // ------------------------------------------------------------------
    // Event qualification
    // ------------------------------------------------------------------
    logic        w_reg_ev;
    logic        w_st_ev;
    logic        w_ld_ev;
    logic        w_mem_ev;
    trace_kind_e w_mem_kind;

    // x0 writes are architecturally invisible and are not traced.
    assign w_reg_ev   = reg_write_sig && (reg_num != 5'd0);
    // A simultaneous wr and rd is reported once, as a store.
    assign w_st_ev    = wr;
    assign w_ld_ev    = rd && !wr;
    assign w_mem_ev   = w_st_ev || w_ld_ev;
    assign w_mem_kind = w_st_ev ? TK_STORE : TK_LOAD;

    logic [c_REC_W-1:0] w_reg_rec;
    logic [c_REC_W-1:0] w_mem_rec;

    assign w_reg_rec = {TK_REG, (ADDR_W)'(reg_num), reg_data, w_stamp};
    assign w_mem_rec = {w_mem_kind, addr, (w_st_ev ? wr_data : rd_data), w_stamp};

    // ------------------------------------------------------------------
    // Ordering and space allocation
    // ------------------------------------------------------------------
    // Slot 0 always carries the earliest-ordered event, so when only one
    // slot is free the register event wins over the memory event.
    logic [c_REC_W-1:0] w_slot0;
    logic [c_REC_W-1:0] w_slot1;
    logic [1:0]         w_n_req;
    logic [1:0]         w_n_push;
    logic [1:0]         w_n_drop;
    logic [c_LVL_W-1:0] w_avail;
    logic               w_pop;

    assign w_slot0 = w_reg_ev ? w_reg_rec : w_mem_rec;
    assign w_slot1 = w_mem_rec;
    assign w_pop   = out_valid && out_ready;

    always_comb begin
        w_n_req  = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};
        w_n_push = w_n_req;
        // Short of space, avail is 0 or 1 here, so its low bits suffice.
        if ((c_LVL_W)'(w_n_req) > w_avail) begin
            w_n_push = w_avail[1:0];
        end
        w_n_drop = w_n_req - w_n_push;
    end

    // ------------------------------------------------------------------
    // Record queue
    // ------------------------------------------------------------------
    trace_fifo_2w1r #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push_cnt   (w_n_push),
        .i_push_data0 (w_slot0),
        .i_push_data1 (w_slot1),
        .i_pop        (w_pop),
        .o_head_data  (out_record),
        .o_head_valid (out_valid),
        .o_level      (level),
        .o_avail      (w_avail)
    );

    // ------------------------------------------------------------------
    // Dropped-event counter (saturating)
    // ------------------------------------------------------------------
    logic [OVF_W-1:0] r_ovf;
    logic [OVF_W:0]   w_ovf_sum;

    // One guard bit catches any carry out of the counter.
    assign w_ovf_sum = {1'b0, r_ovf} + (OVF_W+1)'(w_n_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else if (w_ovf_sum[OVF_W]) begin
            r_ovf <= '1;
        end else begin
            r_ovf <= w_ovf_sum[OVF_W-1:0];
        end
    end

    assign overflow_cnt = r_ovf;

endmodule : commit_trace_buffer
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Self-checking bench for commit_trace_buffer. A queue-based
//               reference model predicts the records, occupancy and drop
//               count; a monitor pops expected records on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 16;
    localparam int OVF_W  = 8;
    localparam int REC_W  = 2 + ADDR_W + DATA_W + TS_W;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

`ifdef TRACE_TIMESTAMP_EN
    localparam logic [TS_W-1:0] STAMP_MASK = '1;
`else
    localparam logic [TS_W-1:0] STAMP_MASK = '0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  reg_write_sig;
    logic [4:0]            reg_num;
    logic [DATA_W-1:0]     reg_data;
    logic                  wr;
    logic                  rd;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [REC_W-1:0]      out_record;
    logic [$clog2(DEPTH):0] level;
    logic [OVF_W-1:0]      overflow_cnt;

    always #5 clk = ~clk;

    commit_trace_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .OVF_W  (OVF_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_record    (out_record),
        .level         (level),
        .overflow_cnt  (overflow_cnt)
    );

    // Reference model state
    logic [REC_W-1:0] sb[$];
    int m_level;
    int m_ovf;
    int m_cyc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REC_W-1:0] make_rec(input logic [1:0] kind, input logic [ADDR_W-1:0] tag,
                                                  input logic [DATA_W-1:0] data, input int cyc);
        logic [TS_W-1:0] st;
        st = TS_W'(cyc) & STAMP_MASK;
        return {kind, tag, data, st};
    endfunction

    task automatic idle_inputs();
        reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
        wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then check occupancy,
    // valid and drop count just after the edge.
    task automatic step(input bit rw, input logic [4:0] rn, input logic [DATA_W-1:0] rdat,
                        input bit w, input bit r, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdd, input bit rdy);
        logic [REC_W-1:0] evs[$];
        int pop;
        int avail;
        int drop;
        reg_write_sig = rw; reg_num = rn; reg_data = rdat;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
        out_ready = rdy;
        if (rw && rn != 5'd0) evs.push_back(make_rec(2'b00, {4'b0000, rn}, rdat, m_cyc));
        if (w)      evs.push_back(make_rec(2'b01, a, wd, m_cyc));
        else if (r) evs.push_back(make_rec(2'b10, a, rdd, m_cyc));
        pop   = (m_level > 0 && rdy) ? 1 : 0;
        avail = DEPTH - m_level + pop;
        drop  = 0;
        foreach (evs[i]) begin
            if (avail > 0) begin
                sb.push_back(evs[i]);
                avail--;
                m_level++;
            end else begin
                drop++;
            end
        end
        m_level -= pop;
        m_ovf = (m_ovf + drop > OVF_MAX) ? OVF_MAX : m_ovf + drop;
        @(posedge clk); #1;
        m_cyc++;
        check("level", 64'(level), 64'(m_level));
        check("out_valid", 64'(out_valid), 64'(m_level != 0));
        check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic rand_step(input int ready_pct);
        step(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0),
             ADDR_W'($urandom), $urandom, $urandom,
             ($urandom_range(0, 99) < ready_pct));
    endtask

    // Hold reset with active strobes, release, and check the cleared state.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'($urandom_range(1, 31)); reg_data = $urandom;
            wr = 1'b1; rd = 1'b1; addr = ADDR_W'($urandom); wr_data = $urandom; rd_data = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        sb.delete();
        m_level = 0;
        m_ovf   = 0;
        m_cyc   = 0;
        check("rst_level", 64'(level), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow_cnt), 64'd0);
        check("rst_out_record", 64'(out_record), 64'd0);
    endtask

    // Monitor: retire expected records on each handshake and check that a
    // stalled head does not change.
    initial begin
        logic [REC_W-1:0] held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_hold", 64'(out_record), 64'(held));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL record: got %h expected no record at %0t", out_record, $time);
                    end else begin
                        check("record", 64'(out_record), 64'(sb.pop_front()));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = out_record;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        m_level = 0; m_ovf = 0; m_cyc = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        do_reset(3);

        // Single register write, stalled for three cycles, then an x0 write.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("reg_rec_direct", 64'(out_record), 64'(make_rec(2'b00, 9'd5, 32'hDEAD_BEEF, 0)));
        idle_step(1'b0);
        idle_step(1'b0);
        idle_step(1'b0);
        step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) idle_step(1'b1);

        // Register and store in one cycle: REG first, then STORE.
        step(1'b1, 5'd7, 32'h1, 1'b1, 1'b0, 9'h010, 32'h55, '0, 1'b0);
        check("dual_level", 64'(level), 64'd2);
        repeat (4) idle_step(1'b1);

        // Fill with four dual events, then three more overflow completely.
        for (int i = 0; i < 7; i++)
            step(1'b1, 5'(i + 1), $urandom, 1'b1, 1'b0, ADDR_W'(i), $urandom, '0, 1'b0);
        check("full_ovf", 64'(overflow_cnt), 64'd6);

        // Full, pop and a single load: no drop, level stays at DEPTH.
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 9'h1FF, '0, 32'h1, 1'b1);
        // Full, pop and two events: one kept, one dropped.
        step(1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 1'b0, 9'h0AA, 32'h0BAD, '0, 1'b1);
        // wr and rd together: a single STORE.
        step(1'b0, 5'd0, '0, 1'b1, 1'b1, 9'h033, 32'h3333, 32'h4444, 1'b1);
        repeat (DEPTH + 2) idle_step(1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 140; i++)
            step(1'b1, 5'd3, $urandom, 1'b0, 1'b1, ADDR_W'($urandom), '0, $urandom, 1'b0);
        check("ovf_saturated", 64'(overflow_cnt), 64'(OVF_MAX));

        // Reset during a drain discards everything.
        step(1'b1, 5'd4, $urandom, 1'b1, 1'b0, 9'h004, $urandom, '0, 1'b1);
        do_reset(2);

        // Capture-cycle stamps at cycles 3 and 10.
        repeat (3) idle_step(1'b0);
        step(1'b1, 5'd11, 32'hAAAA_0003, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("stamp_c3", 64'(out_record[TS_W-1:0]), 64'(TS_W'(3) & STAMP_MASK));
        repeat (6) idle_step(1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1, 9'h100, '0, 32'hAAAA_0010, 1'b0);
        repeat (4) idle_step(1'b1);

        // Randomized phases with varying sink throughput.
        for (int ph = 0; ph < 6; ph++) begin
            int pct;
            pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 500; i++) rand_step(pct);
        end

        repeat (DEPTH + 2) idle_step(1'b1);
        check("drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_commit_trace_buffer
`default_nettype wire
